// File: rtl/instruction_fetch_pkg.sv
// Shared BF opcode constants, FSM state codes and opcode classification
// used by the fetch stage and its bracket scanner.
package instruction_fetch_pkg;

   localparam logic [3:0] OP_HALT  = 4'd0;
   localparam logic [3:0] OP_INC   = 4'd1;
   localparam logic [3:0] OP_DEC   = 4'd2;
   localparam logic [3:0] OP_RIGHT = 4'd3;
   localparam logic [3:0] OP_LEFT  = 4'd4;
   localparam logic [3:0] OP_OPEN  = 4'd5;
   localparam logic [3:0] OP_CLOSE = 4'd6;
   localparam logic [3:0] OP_OUT   = 4'd7;
   localparam logic [3:0] OP_IN    = 4'd8;

   localparam logic [2:0] ST_RUN       = 3'd0;
   localparam logic [2:0] ST_SCAN_FWD  = 3'd1;
   localparam logic [2:0] ST_SCAN_BACK = 3'd2;
   localparam logic [2:0] ST_HALT      = 3'd3;
   localparam logic [2:0] ST_ERROR     = 3'd4;

   typedef enum logic [2:0] {
      CLS_EXEC,
      CLS_NOP,
      CLS_HALT,
      CLS_OPEN,
      CLS_CLOSE
   } op_class_e;

   function automatic op_class_e classify_op(input logic [3:0] op);
      op_class_e cls;
      case (op)
         OP_HALT:  cls = CLS_HALT;
         OP_OPEN:  cls = CLS_OPEN;
         OP_CLOSE: cls = CLS_CLOSE;
         OP_INC, OP_DEC, OP_RIGHT, OP_LEFT, OP_OUT, OP_IN: cls = CLS_EXEC;
         default:  cls = CLS_NOP;
      endcase
      return cls;
   endfunction

endpackage

// File: rtl/instruction_fetch_bracket_scanner.sv
// Bracket nesting counter for forward/backward scans: reports the matching
// bracket and flags depth overflow or a HALT hit while scanning forward.
module instruction_fetch_bracket_scanner
   import instruction_fetch_pkg::*;
#(
   parameter int DEPTH_WIDTH = 8
) (
   input  logic       clk,
   input  logic       srst,
   input  logic       load,
   input  logic       scan_en,
   input  logic       scan_back,
   input  logic [3:0] opcode,
   output logic       match,
   output logic       error
);

   logic [DEPTH_WIDTH-1:0] depth_reg;
   logic [DEPTH_WIDTH-1:0] depth_next;
   logic                   is_nest;
   logic                   is_close;
   logic                   depth_one;
   logic                   depth_full;

   always_comb begin
      // Direction decides which bracket nests deeper and which unwinds.
      is_nest    = scan_back ? (opcode == OP_CLOSE) : (opcode == OP_OPEN);
      is_close   = scan_back ? (opcode == OP_OPEN) : (opcode == OP_CLOSE);
      depth_one  = (depth_reg == DEPTH_WIDTH'(1));
      depth_full = &depth_reg;
      match      = scan_en & is_close & depth_one;
      error      = scan_en & ((is_nest & depth_full) | (~scan_back & (opcode == OP_HALT)));

      depth_next = depth_reg;
      if (load) begin
         depth_next = DEPTH_WIDTH'(1);
      end else if (scan_en) begin
         if (is_nest && !depth_full) begin
            depth_next = depth_reg + DEPTH_WIDTH'(1);
         end else if (is_close) begin
            depth_next = depth_reg - DEPTH_WIDTH'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (srst) begin
         depth_reg <= '0;
      end else begin
         depth_reg <= depth_next;
      end
   end

endmodule

// File: rtl/instruction_fetch.sv
// BF program counter and control-flow stage: offers executable opcodes to
// execute, resolves brackets by scanning the ROM, and latches halt/error.
module instruction_fetch
   import instruction_fetch_pkg::*;
#(
   parameter int DATA_WIDTH  = 4,
   parameter int ADDR_WIDTH  = 8,
   parameter int DEPTH_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   output logic [ADDR_WIDTH-1:0] rom_address,
   input  logic [DATA_WIDTH-1:0] rom_data,
   output logic [DATA_WIDTH-1:0] instr,
   output logic                  instr_valid,
   input  logic                  instr_ready,
   input  logic                  exec_idle,
   input  logic                  cell_zero,
   output logic                  halted,
   output logic                  error
);

   logic [ADDR_WIDTH-1:0] pc_reg;
   logic [ADDR_WIDTH-1:0] pc_next;
   logic [ADDR_WIDTH-1:0] pc_inc;
   logic [ADDR_WIDTH-1:0] pc_dec;
   logic [2:0]            state_reg;
   logic [2:0]            state_next;
   op_class_e             op_class;
   logic                  pc_max;
   logic                  pc_zero;
   logic                  advance;
   logic                  scan_load;
   logic                  scan_en;
   logic                  scan_back;
   logic                  scan_match;
   logic                  scan_error;

   assign op_class = classify_op(rom_data[3:0]);
   assign pc_inc   = pc_reg + ADDR_WIDTH'(1);
   assign pc_dec   = pc_reg - ADDR_WIDTH'(1);
   assign pc_max   = &pc_reg;
   assign pc_zero  = (pc_reg == '0);

   instruction_fetch_bracket_scanner #(
      .DEPTH_WIDTH(DEPTH_WIDTH)
   ) u_scanner (
      .clk      (clk),
      .srst     (reset),
      .load     (scan_load),
      .scan_en  (scan_en),
      .scan_back(scan_back),
      .opcode   (rom_data[3:0]),
      .match    (scan_match),
      .error    (scan_error)
   );

   always_comb begin
      state_next = state_reg;
      pc_next    = pc_reg;
      advance    = 1'b0;
      scan_load  = 1'b0;
      scan_en    = 1'b0;
      scan_back  = 1'b0;
      case (state_reg)
         ST_RUN: begin
            case (op_class)
               CLS_EXEC: advance = instr_ready;
               CLS_NOP:  advance = 1'b1;
               CLS_HALT: if (exec_idle) state_next = ST_HALT;
               CLS_OPEN: begin
                  if (exec_idle) begin
                     if (!cell_zero) begin
                        advance = 1'b1;
                     end else if (pc_max) begin
                        state_next = ST_ERROR;
                     end else begin
                        scan_load  = 1'b1;
                        pc_next    = pc_inc;
                        state_next = ST_SCAN_FWD;
                     end
                  end
               end
               CLS_CLOSE: begin
                  if (exec_idle) begin
                     if (cell_zero) begin
                        advance = 1'b1;
                     end else if (pc_zero) begin
                        state_next = ST_ERROR;
                     end else begin
                        scan_load  = 1'b1;
                        pc_next    = pc_dec;
                        state_next = ST_SCAN_BACK;
                     end
                  end
               end
               default: ;
            endcase
         end
         ST_SCAN_FWD: begin
            scan_en = 1'b1;
            if (scan_error) begin
               state_next = ST_ERROR;
            end else if (scan_match) begin
               state_next = ST_RUN;
               advance    = 1'b1;
            end else if (pc_max) begin
               state_next = ST_ERROR;
            end else begin
               pc_next = pc_inc;
            end
         end
         ST_SCAN_BACK: begin
            scan_en   = 1'b1;
            scan_back = 1'b1;
            if (scan_error) begin
               state_next = ST_ERROR;
            end else if (scan_match) begin
               state_next = ST_RUN;
               pc_next    = pc_inc;
            end else if (pc_zero) begin
               state_next = ST_ERROR;
            end else begin
               pc_next = pc_dec;
            end
         end
         default: ;
      endcase
      // Stepping past the last ROM word ends the program without wrapping.
      if (advance) begin
         if (pc_max) begin
            state_next = ST_HALT;
         end else begin
            pc_next = pc_inc;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pc_reg    <= '0;
         state_reg <= ST_RUN;
      end else begin
         pc_reg    <= pc_next;
         state_reg <= state_next;
      end
   end

   assign rom_address = pc_reg;
   assign instr       = rom_data;
   assign instr_valid = ~reset & (state_reg == ST_RUN) & (op_class == CLS_EXEC);
   assign halted      = (state_reg == ST_HALT);
   assign error       = (state_reg == ST_ERROR);

endmodule
